// File: rtl/fir_ctrl_pkg.sv
// Shared FSM state type and default build constants for the FIR tap sequencer.
package fir_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_LENGTH       = 64;
   localparam int DEF_SEL_WIDTH    = 8;
   localparam int DEF_MULT_LATENCY = 0;

endpackage

// File: rtl/fir_controller.sv
// FIR tap sequencer: one sample per LENGTH+MULT_LATENCY+2 cycles, output_valid LENGTH+MULT_LATENCY edges after accept.
// Backpressure: input_ready only in IDLE; optional FIR_CTRL_WARMUP_EN masks output_valid until the delay line is full.
module fir_controller
   import fir_ctrl_pkg::*;
#(
   parameter int LENGTH       = DEF_LENGTH,
   parameter int SEL_WIDTH    = DEF_SEL_WIDTH,
   parameter int MULT_LATENCY = DEF_MULT_LATENCY
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 input_valid,
   output logic                 input_ready,
   output logic                 Load_FIR_input,
   output logic                 shift_enable,
   output logic [SEL_WIDTH-1:0] Filter_coefficeint_select,
   output logic                 reset_FIR_output,
   output logic                 output_valid,
   output logic                 busy
);

   localparam int CNT_W = $clog2(LENGTH) + 1;
   localparam int DRN_W = 3;
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(LENGTH - 1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   tap_cnt, tap_cnt_nxt;
   logic [DRN_W-1:0]   drn_cnt, drn_cnt_nxt;
   logic               accept;
   logic               sum_done;

   // Reset gates the accept so nothing loads while the block is held in reset.
   assign accept = (state == IDLE) && input_valid && reset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         tap_cnt <= '0;
         drn_cnt <= '0;
      end else begin
         state   <= state_nxt;
         tap_cnt <= tap_cnt_nxt;
         drn_cnt <= drn_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt                 = state;
      tap_cnt_nxt               = tap_cnt;
      drn_cnt_nxt               = drn_cnt;
      input_ready               = 1'b0;
      Load_FIR_input            = 1'b0;
      shift_enable              = 1'b0;
      Filter_coefficeint_select = '0;
      reset_FIR_output          = 1'b0;
      sum_done                  = 1'b0;
      busy                      = 1'b1;
      unique case (state)
         IDLE: begin
            input_ready      = 1'b1;
            reset_FIR_output = 1'b1;
            busy             = 1'b0;
            if (accept) begin
               Load_FIR_input = 1'b1;
               shift_enable   = 1'b1;
               tap_cnt_nxt    = '0;
               state_nxt      = ACCUM;
            end
         end
         ACCUM: begin
            Filter_coefficeint_select = SEL_WIDTH'(tap_cnt);
            // Products still in the multiplier pipeline are stale until it fills.
            reset_FIR_output = (tap_cnt < CNT_W'(MULT_LATENCY));
            if (tap_cnt == LAST_TAP) begin
               drn_cnt_nxt = '0;
               state_nxt   = (MULT_LATENCY > 0) ? DRAIN : DONE;
            end else begin
               tap_cnt_nxt = tap_cnt + CNT_W'(1);
            end
         end
         DRAIN: begin
            Filter_coefficeint_select = SEL_WIDTH'(LENGTH - 1);
            if (drn_cnt == DRN_W'(MULT_LATENCY - 1)) state_nxt = DONE;
            else                                     drn_cnt_nxt = drn_cnt + DRN_W'(1);
         end
         DONE: begin
            sum_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef FIR_CTRL_WARMUP_EN
   localparam int FILL_W = $clog2(LENGTH + 1);
   logic [FILL_W-1:0] fill_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                       fill_cnt <= '0;
      else if (accept && fill_cnt != FILL_W'(LENGTH))   fill_cnt <= fill_cnt + FILL_W'(1);
   end

   assign output_valid = sum_done && (fill_cnt == FILL_W'(LENGTH));
`else
   assign output_valid = sum_done;
`endif

endmodule

// File: tb/tb_fir_controller.sv
// Directed, table-driven bench for fir_controller across three parameter sets.
module tb_fir_controller;

   logic clk;
   logic rst_n;
   logic iv_a, iv_b, iv_c;
   int   cur;

   logic       rdy_a, ld_a, sh_a, rfo_a, ov_a, bsy_a;
   logic [7:0] sel_a;
   logic       rdy_b, ld_b, sh_b, rfo_b, ov_b, bsy_b;
   logic [7:0] sel_b;
   logic       rdy_c, ld_c, sh_c, rfo_c, ov_c, bsy_c;
   logic [7:0] sel_c;

   logic [12:0] act_vec;

   typedef struct {
      logic        iv;
      logic [12:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   fir_controller #(.LENGTH(64), .SEL_WIDTH(8), .MULT_LATENCY(0)) u_a (
      .clk(clk), .reset(rst_n), .input_valid(iv_a), .input_ready(rdy_a),
      .Load_FIR_input(ld_a), .shift_enable(sh_a), .Filter_coefficeint_select(sel_a),
      .reset_FIR_output(rfo_a), .output_valid(ov_a), .busy(bsy_a));

   fir_controller #(.LENGTH(64), .SEL_WIDTH(8), .MULT_LATENCY(2)) u_b (
      .clk(clk), .reset(rst_n), .input_valid(iv_b), .input_ready(rdy_b),
      .Load_FIR_input(ld_b), .shift_enable(sh_b), .Filter_coefficeint_select(sel_b),
      .reset_FIR_output(rfo_b), .output_valid(ov_b), .busy(bsy_b));

   fir_controller #(.LENGTH(4), .SEL_WIDTH(8), .MULT_LATENCY(1)) u_c (
      .clk(clk), .reset(rst_n), .input_valid(iv_c), .input_ready(rdy_c),
      .Load_FIR_input(ld_c), .shift_enable(sh_c), .Filter_coefficeint_select(sel_c),
      .reset_FIR_output(rfo_c), .output_valid(ov_c), .busy(bsy_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      act_vec = '0;
      case (cur)
         0: act_vec = {rdy_a, ld_a, sh_a, sel_a, rfo_a, ov_a, bsy_a};
         1: act_vec = {rdy_b, ld_b, sh_b, sel_b, rfo_b, ov_b, bsy_b};
         default: act_vec = {rdy_c, ld_c, sh_c, sel_c, rfo_c, ov_c, bsy_c};
      endcase
   end

   function automatic logic [12:0] pk(input logic rdy, input logic ld, input logic sh,
                                      input int sel, input logic rfo, input logic ov,
                                      input logic bsy);
      logic [7:0] s;
      s = 8'(sel);
      return {rdy, ld, sh, s, rfo, ov, bsy};
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
   endtask

   task automatic drive(input logic v);
      case (cur)
         0: iv_a = v;
         1: iv_b = v;
         default: iv_c = v;
      endcase
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Single-sample sequence for LENGTH=64 with the given multiplier latency.
   task automatic build_single(input int ml);
      vec_t v;
      tbl.delete();
      v.iv = 1'b1; v.exp = pk(1, 1, 1, 0, 1, 0, 0); tbl.push_back(v);
      for (int i = 0; i < 64; i++) begin
         v.iv = 1'b0; v.exp = pk(0, 0, 0, i, (i < ml), 0, 1); tbl.push_back(v);
      end
      for (int i = 0; i < ml; i++) begin
         v.iv = 1'b0; v.exp = pk(0, 0, 0, 63, 0, 0, 1); tbl.push_back(v);
      end
      v.iv = 1'b0; v.exp = pk(0, 0, 0, 0, 0, 1, 1); tbl.push_back(v);
      v.iv = 1'b0; v.exp = pk(1, 0, 0, 0, 1, 0, 0); tbl.push_back(v);
   endtask

   task automatic run_table(input string name);
      foreach (tbl[i]) begin
         drive(tbl[i].iv);
         @(negedge clk);
         chk(name, i, 32'(act_vec), 32'(tbl[i].exp));
         next_cycle();
      end
   endtask

   initial begin
      int   loads[$];
      int   viol, ovn, found, exp_ov;
      logic idle_seen;

      cur = 0; rst_n = 1'b0;
      iv_a = 1'b1; iv_b = 1'b0; iv_c = 1'b0;
      #3;
      chk("reset_state", 0, 32'(act_vec), 32'(pk(1, 0, 0, 0, 1, 0, 0)));
      next_cycle();
      iv_a = 1'b0;
      rst_n = 1'b1;
      next_cycle();

      cur = 0; build_single(0); run_table("single_ml0");
      cur = 1; build_single(2); run_table("single_ml2");

      // Back-to-back samples with input_valid held high.
      cur = 0; viol = 0; ovn = 0;
      drive(1'b1);
      for (int c = 0; c < 198; c++) begin
         @(negedge clk);
         if (ld_a) loads.push_back(c);
         if (ld_a && bsy_a) viol++;
         if (ov_a) ovn++;
         next_cycle();
      end
      drive(1'b0);
      chk("tput_loads", 0, 32'(loads.size()), 32'd3);
      chk("tput_gap1", 0, (loads.size() >= 2) ? 32'(loads[1] - loads[0]) : 32'hFFFF, 32'd66);
      chk("tput_gap2", 0, (loads.size() >= 3) ? 32'(loads[2] - loads[1]) : 32'hFFFF, 32'd66);
      chk("tput_busy_accept", 0, 32'(viol), 32'd0);
      chk("tput_ovalid", 0, 32'(ovn), 32'd3);
      idle_seen = 1'b0;
      for (int c = 0; c < 100 && !idle_seen; c++) begin
         @(negedge clk);
         if (!bsy_a) idle_seen = 1'b1;
         next_cycle();
      end
      chk("tput_idle", 0, 32'(idle_seen), 32'd1);

      // Reset asserted in the middle of ACCUM.
      drive(1'b1);
      @(negedge clk);
      next_cycle();
      drive(1'b0);
      found = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (sel_a == 8'd30) begin
            found = 1;
            break;
         end
         next_cycle();
      end
      chk("rst_mid_reach30", 0, 32'(found), 32'd1);
      #1 rst_n = 1'b0;
      #1 chk("rst_mid_async", 0, 32'(act_vec), 32'(pk(1, 0, 0, 0, 1, 0, 0)));
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      ovn = 0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (ov_a) ovn++;
         next_cycle();
      end
      chk("rst_mid_no_ovalid", 0, 32'(ovn), 32'd0);
      drive(1'b1);
      @(negedge clk);
      chk("rst_restart_accept", 0, 32'(act_vec), 32'(pk(1, 1, 1, 0, 1, 0, 0)));
      next_cycle();
      drive(1'b0);
      @(negedge clk);
      chk("rst_restart_sel0", 0, 32'(act_vec), 32'(pk(0, 0, 0, 0, 0, 0, 1)));
      next_cycle();
      @(negedge clk);
      chk("rst_restart_sel1", 0, 32'(act_vec), 32'(pk(0, 0, 0, 1, 0, 0, 1)));
      idle_seen = 1'b0;
      for (int c = 0; c < 100 && !idle_seen; c++) begin
         next_cycle();
         @(negedge clk);
         if (!bsy_a) idle_seen = 1'b1;
      end
      chk("rst_restart_idle", 0, 32'(idle_seen), 32'd1);
      next_cycle();

      // Short filter: warm-up masking when enabled, every sample otherwise.
      cur = 2;
      for (int k = 1; k <= 6; k++) begin
         drive(1'b1);
         @(negedge clk);
         chk("short_accept", k, 32'(ld_c), 32'd1);
         next_cycle();
         drive(1'b0);
         ovn = 0;
         for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ov_c) ovn++;
            next_cycle();
         end
`ifdef FIR_CTRL_WARMUP_EN
         exp_ov = (k >= 4) ? 1 : 0;
`else
         exp_ov = 1;
`endif
         chk("short_ovalid", k, 32'(ovn), 32'(exp_ov));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fir_controller.md
FIR_CONTROLLER -- requirements
Module: fir_controller

Interface
REQ-001 The module SHALL have parameter LENGTH, default 64, meaning the number of filter taps sequenced per output sample.
REQ-002 The module SHALL have parameter SEL_WIDTH, default 8, meaning the width of the coefficient select bus, with LENGTH <= 2**SEL_WIDTH.
REQ-003 The module SHALL have parameter MULT_LATENCY, default 0, meaning the datapath multiplier pipeline depth in cycles, range 0..4.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port input_valid, input, 1 bit: a new sample is present at the datapath FIR_input.
REQ-007 The module SHALL have port input_ready, output, 1 bit: the controller accepts a sample this cycle.
REQ-008 The module SHALL have port Load_FIR_input, output, 1 bit: load the newest-tap register.
REQ-009 The module SHALL have port shift_enable, output, 1 bit: shift the tap delay line by one.
REQ-010 The module SHALL have port Filter_coefficeint_select, output, SEL_WIDTH bits: the tap/coefficient index.
REQ-011 The module SHALL have port reset_FIR_output, output, 1 bit: active-high accumulator clear.
REQ-012 The module SHALL have port output_valid, output, 1 bit: the datapath FIR_output holds a complete sum this cycle.
REQ-013 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, ACCUM, DRAIN, DONE.
REQ-015 In IDLE: input_ready=1 and reset_FIR_output=1; on input_valid=1, Load_FIR_input=shift_enable=1 combinationally in the same cycle, and the next state is ACCUM with tap counter=0.
REQ-016 In ACCUM: Filter_coefficeint_select=counter, and the counter increments each cycle; after the counter reaches LENGTH-1, the next state is DRAIN if MULT_LATENCY>0, else DONE.
REQ-017 reset_FIR_output SHALL stay 1 for the first MULT_LATENCY ACCUM cycles, then 0 through the rest of ACCUM, DRAIN and DONE.
REQ-018 DRAIN SHALL last exactly MULT_LATENCY cycles, with select held at LENGTH-1, then go to DONE.
REQ-019 DONE SHALL last exactly one cycle with output_valid=1, then return to IDLE.
REQ-020 The first output_valid SHALL occur LENGTH+MULT_LATENCY rising edges after the accepting edge; sustained throughput is one sample per LENGTH+MULT_LATENCY+2 cycles.
REQ-021 Outside IDLE: input_ready=0, input_valid is ignored, and Load_FIR_input=shift_enable=0.
REQ-022 Filter_coefficeint_select SHALL be 0 in IDLE and DONE and SHALL never exceed LENGTH-1.
REQ-023 The counter SHALL be $clog2(LENGTH)+1 bits wide and SHALL NOT wrap within ACCUM.

Reset
REQ-024 While reset=0: state=IDLE, counter=0, output_valid=0, Load_FIR_input=0, shift_enable=0, select=0, reset_FIR_output=1, busy=0, input_ready=1 (masked by reset), all applied asynchronously.
REQ-025 Reset asserted mid-ACCUM/DRAIN/DONE SHALL abandon the computation with no output_valid pulse; after release, the first accepted sample starts a clean sequence.

Configuration
REQ-026 FIR_CTRL_WARMUP_EN defined: a saturating fill counter (0..LENGTH) increments per accepted sample; output_valid is suppressed until LENGTH samples have been accepted, while FSM timing is unchanged.
REQ-027 FIR_CTRL_WARMUP_EN undefined: there is no fill counter, and output_valid pulses for every sample including the first.

Structure
REQ-028 The shared package fir_ctrl_pkg SHALL hold the state typedef (IDLE/ACCUM/DRAIN/DONE) and the default constants for LENGTH, SEL_WIDTH and MULT_LATENCY.
REQ-029 No sub-module is required; the FSM, tap counter, drain counter and optional fill counter are inline.

Verification
REQ-030 Reset, LENGTH=64, MULT_LATENCY=0, input_valid pulse at edge 0 -> select runs 0..63 over edges 1..64, output_valid high exactly one cycle after edge 64, input_ready high again next cycle.
REQ-031 MULT_LATENCY=2, one sample -> reset_FIR_output high for the first 2 ACCUM cycles, 2 DRAIN cycles, output_valid after edge 66.
REQ-032 input_valid held high continuously for 3 samples, MULT_LATENCY=0 -> exactly 3 Load_FIR_input pulses spaced 66 cycles apart, no accepts while busy=1.
REQ-033 reset driven low at ACCUM select=30 -> all outputs at reset values immediately, no output_valid, and the next sample restarts at select=0.
REQ-034 FIR_CTRL_WARMUP_EN, LENGTH=4 -> no output_valid for samples 1-3, output_valid for sample 4 and every later sample.
